// File: rtl/gaplus_vid_pkg.sv
// Shared video definitions for the Gaplus video mixer.
// Latency, transparent lookup code and pixel source select codes.
package gaplus_vid_pkg;

   localparam int         VMIX_LAT    = 5;
   localparam logic [7:0] SPCL_TRANSP = 8'hFF;

   typedef enum logic [1:0] {
      NONE   = 2'd0,
      BG     = 2'd1,
      SPRITE = 2'd2
   } vmix_sel_e;

endpackage

// File: rtl/gaplus_vmix_if.sv
// Pixel, lookup ROM and palette PROM signals of the video mixer.
// master drives pixels and ROM data; slave is the mixer.
interface gaplus_vmix_if;

   logic        HB;
   logic        VB;
   logic [8:0]  SP_CLUT;
   logic [7:0]  BG_PIX;
   logic        BG_OPQ;
   logic        BG_PRI;
   logic [5:0]  STAR_PIX;
   logic [8:0]  SPCL_A;
   logic [7:0]  SPCL_D;
   logic [7:0]  PAL_A;
   logic [11:0] PAL_D;
   logic [3:0]  R;
   logic [3:0]  G;
   logic [3:0]  B;
   logic        HBO;
   logic        VBO;

   modport master (
      output HB, VB, SP_CLUT, BG_PIX, BG_OPQ, BG_PRI,
      output STAR_PIX, SPCL_D, PAL_D,
      input  SPCL_A, PAL_A, R, G, B, HBO, VBO
   );

   modport slave (
      input  HB, VB, SP_CLUT, BG_PIX, BG_OPQ, BG_PRI,
      input  STAR_PIX, SPCL_D, PAL_D,
      output SPCL_A, PAL_A, R, G, B, HBO, VBO
   );

endinterface

// File: rtl/gaplus_vdelay.sv
// Fixed-depth shift register for sideband alignment.
// Reset loads every stage with rst_val_i.
module gaplus_vdelay #(
   parameter int W = 1,
   parameter int D = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] rst_val_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] sr_q [D];

   // shift one stage per pixel clock
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < D; i++) sr_q[i] <= rst_val_i;
      end else begin
         sr_q[0] <= d_i;
         for (int i = 1; i < D; i++) sr_q[i] <= sr_q[i-1];
      end
   end

   assign q_o = sr_q[D-1];

endmodule

// File: rtl/gaplus_vmix.sv
// Gaplus video mixer: sprite/background priority, palette, starfield.
// Optional starfield insertion: define STARFIELD_EN.
module gaplus_vmix
   import gaplus_vid_pkg::*;
(
   input  logic               VCLK,
   input  logic               RESET_N,
   gaplus_vmix_if.slave       bus
);

   logic [8:0]  spcl_a_q;
   logic [7:0]  spcl_d_q;
   logic [7:0]  pal_a_q, pal_a_d;
   logic [11:0] pal_d_q;
   vmix_sel_e   sel3_q, sel4_q, sel_d;
   logic [3:0]  r_q, g_q, b_q, r_d, g_d, b_d;
   logic        hbo_q, vbo_q;
   logic [10:0] bg2;
   logic [1:0]  blk4;
   logic        sp_opq;

   // background fields and sprite-present flag, aligned with SPCL_D
   gaplus_vdelay #(.W(11), .D(2)) u_bg (
      .clk       (VCLK),
      .rst_n     (RESET_N),
      .rst_val_i (11'd0),
      .d_i       ({bus.BG_PIX, bus.BG_OPQ, bus.BG_PRI,
                   bus.SP_CLUT != 9'd0}),
      .q_o       (bg2)
   );

   // blanking resets to active so the pipeline flushes as blank
   gaplus_vdelay #(.W(2), .D(VMIX_LAT-1)) u_blk (
      .clk       (VCLK),
      .rst_n     (RESET_N),
      .rst_val_i (2'b11),
      .d_i       ({bus.HB, bus.VB}),
      .q_o       (blk4)
   );

`ifdef STARFIELD_EN
   logic [5:0] star4;

   gaplus_vdelay #(.W(6), .D(VMIX_LAT-1)) u_star (
      .clk       (VCLK),
      .rst_n     (RESET_N),
      .rst_val_i (6'd0),
      .d_i       (bus.STAR_PIX),
      .q_o       (star4)
   );
`else
   logic unused_nc;
   assign unused_nc = ^{bus.STAR_PIX, sel4_q};
`endif

   // transparent code or empty sprite address never wins
   assign sp_opq = bg2[0] && (spcl_d_q != SPCL_TRANSP);

   // priority select: opaque prioritised background beats sprite
   always_comb begin
      sel_d   = NONE;
      pal_a_d = 8'h00;
      if (sp_opq && !(bg2[2] && bg2[1])) begin
         sel_d   = SPRITE;
         pal_a_d = spcl_d_q;
      end else if (bg2[2]) begin
         sel_d   = BG;
         pal_a_d = bg2[10:3];
      end
   end

   // final colour: blanking, then starfield, then palette
   always_comb begin
      r_d = pal_d_q[11:8];
      g_d = pal_d_q[7:4];
      b_d = pal_d_q[3:0];
      if (blk4 != 2'b00) begin
         r_d = 4'h0;
         g_d = 4'h0;
         b_d = 4'h0;
`ifdef STARFIELD_EN
      end else if (sel4_q == NONE && star4 != 6'd0) begin
         r_d = {star4[5:4], star4[5:4]};
         g_d = {star4[3:2], star4[3:2]};
         b_d = {star4[1:0], star4[1:0]};
`endif
      end
   end

   // main pipeline registers, edges one through five
   always_ff @(posedge VCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         spcl_a_q <= 9'd0;
         spcl_d_q <= 8'd0;
         pal_a_q  <= 8'd0;
         sel3_q   <= NONE;
         pal_d_q  <= 12'd0;
         sel4_q   <= NONE;
         r_q      <= 4'd0;
         g_q      <= 4'd0;
         b_q      <= 4'd0;
         hbo_q    <= 1'b1;
         vbo_q    <= 1'b1;
      end else begin
         spcl_a_q <= bus.SP_CLUT;
         spcl_d_q <= bus.SPCL_D;
         pal_a_q  <= pal_a_d;
         sel3_q   <= sel_d;
         pal_d_q  <= bus.PAL_D;
         sel4_q   <= sel3_q;
         r_q      <= r_d;
         g_q      <= g_d;
         b_q      <= b_d;
         hbo_q    <= blk4[1];
         vbo_q    <= blk4[0];
      end
   end

   assign bus.SPCL_A = spcl_a_q;
   assign bus.PAL_A  = pal_a_q;
   assign bus.R      = r_q;
   assign bus.G      = g_q;
   assign bus.B      = b_q;
   assign bus.HBO    = hbo_q;
   assign bus.VBO    = vbo_q;

endmodule

// File: doc/gaplus_vmix.md
GAPLUS_VMIX -- requirements
Module: gaplus_vmix

Interface
REQ-001 VCLK  in  1  pixel clock; all state on rising edge.
REQ-002 RESET_N  in  1  asynchronous, active-low reset.
REQ-003 HB, VB  in  1 each  horizontal/vertical blank, aligned to SP_CLUT.
REQ-004 SP_CLUT  in  9  sprite colour-lookup address from the sprite engine line buffer; 0 = no sprite.
REQ-005 BG_PIX  in  8  background palette index.
REQ-006 BG_OPQ  in  1  background pixel opaque.
REQ-007 BG_PRI  in  1  opaque background pixel has priority over sprites.
REQ-008 STAR_PIX  in  6  starfield colour {R2,G2,B2}; 0 = no star.
REQ-009 SPCL_A  out  9  sprite colour-lookup ROM address.
REQ-010 SPCL_D  in  8  sprite lookup ROM data, valid one VCLK after SPCL_A.
REQ-011 PAL_A  out  8  palette PROM address.
REQ-012 PAL_D  in  12  palette PROM data {R4,G4,B4}, valid one VCLK after PAL_A.
REQ-013 R, G, B  out  4 each  final colour.
REQ-014 HBO, VBO  out  1 each  HB/VB delayed to match R/G/B.

Function
REQ-015 Pipeline SHALL be fixed-latency, no stalls; input sampled at edge n appears on R/G/B/HBO/VBO after edge n+5.
REQ-016 Edge n+1: SPCL_A <= SP_CLUT; BG_PIX, BG_OPQ, BG_PRI, STAR_PIX, HB, VB, and (SP_CLUT!=0) captured in delay stage 1.
REQ-017 Edge n+2: SPCL_D and delayed sidebands registered together (stage 2).
REQ-018 Sprite opaque = delayed (SP_CLUT!=0) AND SPCL_D!=8'hFF.
REQ-019 Edge n+3: PAL_A <= SPCL_D if sprite opaque and not (BG_OPQ AND BG_PRI); else BG_PIX if BG_OPQ; else 8'h00; select code {SPRITE, BG, NONE} delayed alongside.
REQ-020 Edge n+4: PAL_D registered with select code and STAR_PIX delayed.
REQ-021 Edge n+5: if HB or VB (delayed) then R=G=B=0; else if select==NONE and STAR_PIX!=0 then R={STAR_PIX[5:4],STAR_PIX[5:4]}, G, B likewise; else R/G/B = PAL_D fields.
REQ-022 HBO/VBO SHALL equal HB/VB exactly five edges earlier, including across frame boundaries.
REQ-023 Simultaneous sprite opaque, BG opaque and BG_PRI=1: background wins; BG_PRI ignored when BG_OPQ=0.
REQ-024 SP_CLUT=0 SHALL never select sprite regardless of SPCL_D.
REQ-025 Block SHALL contain no combinational path from any input to any output.

Reset
REQ-026 RESET_N low SHALL immediately clear all pipeline registers: SPCL_A=0, PAL_A=0, R=G=B=0, HBO=VBO=1, select codes NONE.
REQ-027 Release mid-line: first five outputs after release SHALL be blanked (HBO=VBO=1, RGB=0), then normal operation.

Configuration
REQ-028 STARFIELD_EN defined: star insertion per REQ-021.
REQ-029 STARFIELD_EN undefined: STAR_PIX ignored, its delay registers absent, NONE pixels output PAL_D for index 0; latency unchanged.

Structure
REQ-030 Shared package gaplus_vid_pkg: latency constant VMIX_LAT=5, transparent code SPCL_TRANSP=8'hFF, select-code typedef {NONE,BG,SPRITE}.
REQ-031 One sub-module GAPLUS_VDELAY: parameterised width/depth shift register with async reset value input, used for sideband alignment.

Verification
REQ-032 SP_CLUT=9'h012, SPCL_D=8'h34, BG_OPQ=0 -> PAL_A=8'h34 after edge 3; R/G/B=PAL_D fields after edge 5.
REQ-033 SP_CLUT=9'h012, SPCL_D=8'hFF, BG_OPQ=1, BG_PIX=8'h56 -> PAL_A=8'h56.
REQ-034 Sprite opaque (SPCL_D=8'h10), BG_OPQ=1, BG_PRI=1, BG_PIX=8'h22 -> PAL_A=8'h22; same with BG_PRI=0 -> 8'h10.
REQ-035 SP_CLUT=0, BG_OPQ=0, STAR_PIX=6'b110100 (STARFIELD_EN) -> R=4'hF, G=4'h5, B=4'h0; without macro -> PAL_D of index 0.
REQ-036 HB pulse of 3 cycles -> HBO identical pulse 5 cycles later, RGB=0 for those 3 cycles.
REQ-037 Assert RESET_N low mid-line with opaque sprites -> outputs cleared same cycle; after release 5 blanked cycles, then correct pixels.
